fifo_drain: RTL and testbench

Read-side controller for the team's 8-bit synchronous FIFO. On a start command it pops a programmed number of bytes from the FIFO, absorbing the FIFO's one-cycle read latency, and forwards them on a valid/ready byte stream with `m_last` marking the final byte. It sits between the FIFO output port and any downstream consumer (serializer, packet builder) that applies backpressure.

---
 rtl/fifo_drain_if.sv | 23 ++
 rtl/fifo_drain.sv | 114 +++++++++++
 tb/tb_fifo_drain.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_drain_if.sv
// FIFO read port plus valid/ready byte stream seen by the drain controller.
// master = the controller side, slave = FIFO/consumer side.
interface fifo_drain_if #(
   parameter int DATA_W = 8
);
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [DATA_W-1:0] fifo_dout;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  fifo_empty, fifo_dout, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last
   );

   modport slave (
      output fifo_empty, fifo_dout, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_drain.sv
// Pops a programmed number of bytes from a 1-cycle-latency FIFO and forwards
// them on a valid/ready stream through a 2-entry skid buffer.
module fifo_drain #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   fifo_drain_if.master     bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state, state_nx;
   logic [LEN_W-1:0]  issue_cnt, send_cnt;
   logic [1:0]        buf_cnt;
   logic              inflight;
   logic [DATA_W-1:0] skid0, skid1;
   logic              pop, rd_en, last_pop, done_nx;
   logic [2:0]        occ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // occ is the buffer+in-flight level after this cycle's pop; issue keeps it below 2.
   always_comb begin
      state_nx = state;
      rd_en    = 1'b0;
      done_nx  = 1'b0;
      pop      = (buf_cnt != 2'd0) && bus.m_ready;
      last_pop = pop && (send_cnt == LEN_W'(1));
      occ      = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) state_nx = RUN;
               else           done_nx  = 1'b1;
            end
         end
         RUN: begin
            rd_en = !bus.fifo_empty && (issue_cnt != '0) && (occ < 3'd2);
            if (last_pop) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (rd_en && (issue_cnt == LEN_W'(1))) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (last_pop) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         send_cnt  <= '0;
         inflight  <= 1'b0;
         buf_cnt   <= 2'd0;
         skid0     <= '0;
         skid1     <= '0;
         done      <= 1'b0;
      end else begin
         done     <= done_nx;
         inflight <= rd_en;
         if (state == IDLE && start && len != '0) begin
            issue_cnt <= len;
            send_cnt  <= len;
         end else begin
            if (rd_en)                    issue_cnt <= issue_cnt - LEN_W'(1);
            if (pop && send_cnt != '0)    send_cnt  <= send_cnt - LEN_W'(1);
         end
         // skid0 is always the head; a simultaneous capture and pop shifts through.
         case ({inflight, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) skid0 <= bus.fifo_dout;
               else                 skid1 <= bus.fifo_dout;
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b01: begin
               skid0   <= skid1;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  skid0 <= bus.fifo_dout;
               end else begin
                  skid0 <= skid1;
                  skid1 <= bus.fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy           = (state != IDLE);
   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (buf_cnt != 2'd0);
   assign bus.m_data     = skid0;
   assign bus.m_last     = bus.m_valid && (send_cnt == LEN_W'(1));

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: transfer vectors in a table plus hand-written
// reset sequences, against a behavioural 1-cycle-latency FIFO.
module tb_fifo_drain;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] len;
   logic       busy, done;

   fifo_drain_if #(.DATA_W(8)) bus ();

   fifo_drain #(.DATA_W(8), .LEN_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .len   (len),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: registered read data one cycle after a pop.
   logic [7:0]  mem [64];
   int unsigned wr_ptr = 0;
   int unsigned rd_ptr = 0;
   int unsigned pop_on_empty = 0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         if (wr_ptr == rd_ptr) begin
            pop_on_empty <= pop_on_empty + 1;
         end else begin
            bus.fifo_dout <= mem[rd_ptr % 64];
            rd_ptr        <= rd_ptr + 1;
         end
      end
   end

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 64] = d;
      wr_ptr++;
   endtask

   typedef struct {
      string       tag;
      int unsigned len;
      logic [7:0]  base;
      logic [7:0]  step;
      int unsigned nfill;
      logic [15:0] rdy;       // m_ready in cycle k (k<16), 1 afterwards
      int unsigned push_cyc;  // cycle in which push_n more bytes arrive (0 = none)
      int unsigned push_n;
      int unsigned x_cyc;     // cycle of an extra start pulse (0 = none)
      int unsigned x_len;
      int unsigned exp_done;  // cycle of the done pulse, start sampled at edge 0
      int unsigned exp_rd;
      int unsigned exp_left;  // bytes left in the FIFO afterwards
   } vec_t;

   vec_t vecs [7];

   task automatic run_xfer(input vec_t v);
      int unsigned nbytes = 0, rdc = 0, done_cyc = 0, ndone = 0;
      int unsigned order_bad = 0, last_bad = 0, stall_bad = 0, busy_bad = 0;
      int unsigned max_occ = 0, occ, left;
      logic        prev_stall = 1'b0;
      logic [7:0]  prev_data = '0, exp_byte;
      logic        prev_last = 1'b0;
      int unsigned empty0 = pop_on_empty;

      wr_ptr = rd_ptr;
      for (int i = 0; i < int'(v.nfill); i++) push(v.base + 8'(i) * v.step);
      @(posedge clk); #1;
      start = 1'b1;
      len   = 8'(v.len);
      @(posedge clk); #1;
      start = 1'b0;
      for (int unsigned k = 1; k <= 40; k++) begin
         bus.m_ready = (k < 16) ? v.rdy[k] : 1'b1;
         if (k == v.x_cyc) begin
            start = 1'b1;
            len   = 8'(v.x_len);
         end else begin
            start = 1'b0;
         end
         if (k == v.push_cyc)
            for (int i = 0; i < int'(v.push_n); i++)
               push(v.base + 8'(v.nfill + i) * v.step);
         @(negedge clk);
         occ = rdc - nbytes;
         if (occ > max_occ) max_occ = occ;
         if (bus.fifo_rd_en) rdc++;
         if (prev_stall && !(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last))
            stall_bad++;
         if (bus.m_valid && bus.m_ready) begin
            exp_byte = v.base + 8'(nbytes) * v.step;
            if (bus.m_data != exp_byte) order_bad++;
            if (bus.m_last != (nbytes + 1 == v.len)) last_bad++;
            nbytes++;
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
         prev_last  = bus.m_last;
         if (done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = k;
            if (busy) busy_bad++;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      left  = wr_ptr - rd_ptr;
      chk({v.tag, " bytes"},      nbytes,    v.len);
      chk({v.tag, " order"},      order_bad, 0);
      chk({v.tag, " last"},       last_bad,  0);
      chk({v.tag, " done_cycle"}, done_cyc,  v.exp_done);
      chk({v.tag, " done_count"}, ndone,     1);
      chk({v.tag, " busy_at_done"}, busy_bad, 0);
      chk({v.tag, " rd_pulses"},  rdc,       v.exp_rd);
      chk({v.tag, " stall_hold"}, stall_bad, 0);
      chk({v.tag, " max_outstanding_le2"}, 32'(max_occ <= 2), 1);
      chk({v.tag, " pop_on_empty"}, pop_on_empty - empty0, 0);
      chk({v.tag, " fifo_left"},  left,      v.exp_left);
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, " busy"},    busy,           0);
      chk({name, " done"},    done,           0);
      chk({name, " rd_en"},   bus.fifo_rd_en, 0);
      chk({name, " m_valid"}, bus.m_valid,    0);
      chk({name, " m_data"},  bus.m_data,     0);
      chk({name, " m_last"},  bus.m_last,     0);
   endtask

   initial begin
      int unsigned ndone;

      vecs[0] = '{"basic",     4, 8'hA0, 8'h01, 4, 16'hFFFF,  0, 0, 0, 0,  7, 4, 0};
      vecs[1] = '{"backpress", 6, 8'h01, 8'h01, 6, 16'h9999,  0, 0, 0, 0, 13, 6, 0};
      vecs[2] = '{"longstall", 3, 8'h30, 8'h01, 3, 16'hFFC0,  0, 0, 0, 0,  9, 3, 0};
      vecs[3] = '{"len1",      1, 8'hC0, 8'h01, 1, 16'hFFFF,  0, 0, 0, 0,  4, 1, 0};
      vecs[4] = '{"underrun",  3, 8'h55, 8'h11, 1, 16'hFFFF, 10, 2, 0, 0, 14, 3, 0};
      vecs[5] = '{"zerolen",   0, 8'h00, 8'h01, 0, 16'hFFFF,  0, 0, 0, 0,  1, 0, 0};
      vecs[6] = '{"startbusy", 2, 8'hE0, 8'h01, 4, 16'hFFFF,  0, 0, 2, 9,  5, 2, 2};

      rst_n       = 1'b0;
      start       = 1'b0;
      len         = '0;
      bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_idle_outputs("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

      // Reset in the middle of a transfer, then a fresh transfer.
      wr_ptr = rd_ptr;
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      len   = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("startup c1 busy",  busy,           1);
      chk("startup c1 rd_en", bus.fifo_rd_en, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_outputs("midrst_c3");
      ndone = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 2) rst_n = 1'b1;
         @(negedge clk);
         if (done) ndone++;
      end
      chk_idle_outputs("midrst_after");
      chk("midrst no_done", ndone, 0);
      run_xfer(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
